// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Write-back scheduler and scoreboard for the integer register file's single
//   write port. It merges the single-cycle ALU result (req0) and the
//   long-latency LSU/MUL result (req1) with round-robin arbitration. A 1-cycle
//   registered write-back stage follows the arbiter. The block also tracks
//   registers with pending long-latency writes and stalls issue on RAW/WAW
//   hazards against them.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     iss_*                       decode/issue handshake and operand info
//     req0_* / req1_*             ALU / LSU-MUL result valid-ready channels
//     wb_en, wb_addr, wb_data     register file write port
//     busy_vec                    scoreboard (bit 0 always 0)
//     perf_stall_cnt              hazard stall cycle counter
//
//   Build option: define SB_PERF_CNT_EN to build the saturating stall counter.
//   Without it, perf_stall_cnt is tied to 0.
module regfile_wb_scheduler #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic              iss_rs1_use,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic              iss_rs2_use,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_wr,
  input  logic              iss_long,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [NREG-1:0]   busy_vec,
  output logic [31:0]       perf_stall_cnt
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } rr_t;

  rr_t               rr_q, rr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              hazard;
  logic              iss_acc;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Hazard uses the registered scoreboard only. A clear becomes visible the
  // cycle after the req1 grant.
  always_comb begin
    hazard = (iss_rs1_use & busy_q[iss_rs1]) |
             (iss_rs2_use & busy_q[iss_rs2]) |
             (iss_rd_wr   & busy_q[iss_rd]);
  end

  assign iss_ready = ~hazard;
  assign iss_acc   = iss_valid & iss_ready;

  // Round-robin arbiter: on contention, the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    rr_d   = rr_q;
    if (req0_valid && req1_valid) begin
      if (rr_q == LAST_REQ1) grant0 = 1'b1;
      else                   grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    if (grant0)      rr_d = LAST_REQ0;
    else if (grant1) rr_d = LAST_REQ1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    win_rd   = req0_rd;
    win_data = req0_data;
    if (grant1) begin
      win_rd   = req1_rd;
      win_data = req1_data;
    end
  end

  // The set is applied after the clear, so a same-register set wins.
  // Register 0 is forced clear.
  always_comb begin
    busy_d = busy_q;
    if (grant1) busy_d[req1_rd] = 1'b0;
    if (iss_acc && iss_long && iss_rd_wr && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= LAST_REQ1;
      busy_q <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
    end
  end

  // Write-back stage. A grant to x0 is consumed but never writes.
  // Address and data hold when there is no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (grant0 || grant1) begin
      wb_en   <= (win_rd != '0);
      wb_addr <= win_rd;
      wb_data <= win_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  assign busy_vec = busy_q;

`ifdef SB_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (iss_valid && hazard && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_use, iss_rs2_use, iss_rd_wr, iss_long;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [63:0] req0_data, req1_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [31:0] busy_vec;
  logic [31:0] perf_stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  regfile_wb_scheduler #(.DATA_W(64), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs1_use(iss_rs1_use),
    .iss_rs2(iss_rs2), .iss_rs2_use(iss_rs2_use),
    .iss_rd(iss_rd), .iss_rd_wr(iss_rd_wr), .iss_long(iss_long),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rd(req1_rd), .req1_data(req1_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rs1 = 0; iss_rs1_use = 0; iss_rs2 = 0; iss_rs2_use = 0;
    iss_rd = 0; iss_rd_wr = 0; iss_long = 0;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model state
  bit          m_busy [32];
  int          m_last;        // 0: req0 granted most recently, 1: req1
  bit          m_wb_en;
  logic [4:0]  m_wb_addr;
  logic [63:0] m_wb_data;
  longint      m_stall;

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_last = 1; m_wb_en = 0; m_wb_addr = 0; m_wb_data = 0; m_stall = 0;
  endtask

  task automatic random_test(input int cycles);
    bit p0, p1, hz, g0, g1;
    p0 = 0; p1 = 0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      // Stimulus: a pending requester holds its values until it is granted.
      iss_valid   = 1'($urandom_range(0, 1));
      iss_rs1     = 5'($urandom_range(0, 7));
      iss_rs2     = 5'($urandom_range(0, 7));
      iss_rd      = 5'($urandom_range(0, 7));
      iss_rs1_use = 1'($urandom_range(0, 1));
      iss_rs2_use = 1'($urandom_range(0, 1));
      iss_rd_wr   = 1'($urandom_range(0, 1));
      iss_long    = 1'($urandom_range(0, 1));
      if (!p0) begin
        req0_valid = ($urandom_range(0, 2) == 0);
        req0_rd    = 5'($urandom_range(0, 7));
        req0_data  = {$urandom, $urandom};
      end
      if (!p1) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_rd    = 5'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
          int r = $urandom_range(1, 7);
          if (m_busy[r]) begin req1_rd = 5'(r); break; end
        end
        req1_data  = {$urandom, $urandom};
      end
      #1;
      hz = (iss_rs1_use && m_busy[iss_rs1]) || (iss_rs2_use && m_busy[iss_rs2]) ||
           (iss_rd_wr && m_busy[iss_rd]);
      g0 = req0_valid && (!req1_valid || m_last == 1);
      g1 = req1_valid && (!req0_valid || m_last == 0);
      check("rnd_iss_ready", iss_ready, !hz);
      check("rnd_req0_ready", req0_ready, g0);
      check("rnd_req1_ready", req1_ready, g1);
      // Model next state
      if (iss_valid && hz && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (g0 || g1) begin
        m_wb_addr = g0 ? req0_rd : req1_rd;
        m_wb_data = g0 ? req0_data : req1_data;
        m_wb_en   = (m_wb_addr != 0);
        m_last    = g0 ? 0 : 1;
      end else begin
        m_wb_en = 0;
      end
      if (g1) m_busy[req1_rd] = 0;
      if (iss_valid && !hz && iss_long && iss_rd_wr && iss_rd != 0) m_busy[iss_rd] = 1;
      p0 = req0_valid && !g0;
      p1 = req1_valid && !g1;
      tick();
      check("rnd_wb_en", wb_en, m_wb_en);
      check("rnd_wb_addr", wb_addr, m_wb_addr);
      check("rnd_wb_data", wb_data, m_wb_data);
      check("rnd_busy_vec", busy_vec, model_busy_vec());
`ifdef SB_PERF_CNT_EN
      check("rnd_perf", perf_stall_cnt, m_stall[31:0]);
`else
      check("rnd_perf", perf_stall_cnt, 0);
`endif
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;

    // Reset check: requester already presenting as reset releases
    req0_valid = 1; req0_rd = 5; req0_data = 64'h11;
    #12;
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_perf", perf_stall_cnt, 0);
    @(negedge clk); rst_n = 1; #1;
    check("rst_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("rst_wb1_en", wb_en, 1);
    check("rst_wb1_addr", wb_addr, 5);
    check("rst_wb1_data", wb_data, 64'h11);
    check("rst_wb1_busy", busy_vec, 0);

    // Long-op RAW stall
    iss_valid = 1; iss_long = 1; iss_rd_wr = 1; iss_rd = 7; #1;
    check("raw_issue_ready", iss_ready, 1);
    tick();
    check("raw_busy7", busy_vec, 32'h80);
    check("raw_wb_idle", wb_en, 0);
    iss_long = 0; iss_rd_wr = 0; iss_rd = 0; iss_rs1 = 7; iss_rs1_use = 1; #1;
    check("raw_stall0", iss_ready, 0);
    tick();
    check("raw_stall1", iss_ready, 0);
    req1_valid = 1; req1_rd = 7; req1_data = 64'hAB; #1;
    check("raw_req1_ready", req1_ready, 1);
    check("raw_stall_grant_cycle", iss_ready, 0);
    tick();
    req1_valid = 0; #1;
    check("raw_unblock", iss_ready, 1);
    check("raw_wb_en", wb_en, 1);
    check("raw_wb_data", wb_data, 64'hAB);
    check("raw_busy_clear", busy_vec, 0);
    iss_valid = 0; iss_rs1_use = 0;

    // Round-robin: last grant was req1, so req0 leads
    req0_valid = 1; req0_rd = 1; req0_data = 64'h101;
    req1_valid = 1; req1_rd = 2; req1_data = 64'h202;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_req0_ready", req0_ready, (i % 2) == 0);
      check("rr_req1_ready", req1_ready, (i % 2) == 1);
      tick();
      check("rr_wb_addr", wb_addr, ((i % 2) == 0) ? 1 : 2);
    end
    req0_valid = 0; req1_valid = 0;

    // Zero register
    iss_valid = 1; iss_long = 1; iss_rd_wr = 1; iss_rd = 0;
    tick();
    check("zero_busy", busy_vec, 0);
    iss_valid = 0; iss_long = 0; iss_rd_wr = 0;
    req0_valid = 1; req0_rd = 0; req0_data = 64'hFF; #1;
    check("zero_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("zero_wb_en", wb_en, 0);

    // WAW and asynchronous reset
    iss_valid = 1; iss_long = 1; iss_rd_wr = 1; iss_rd = 3;
    tick();
    check("waw_busy3", busy_vec, 32'h8);
    iss_long = 0; #1;
    check("waw_stall", iss_ready, 0);
    req0_valid = 1; req0_rd = 4; req0_data = 64'h44;
    tick();
    check("waw_wb_en_before_rst", wb_en, 1);
    #2 rst_n = 0; #1;
    check("arst_busy", busy_vec, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_wb_addr", wb_addr, 0);
    idle_inputs();
    @(negedge clk); rst_n = 1;
    tick();

    // Stall counter: 10 hazard cycles
    iss_valid = 1; iss_long = 1; iss_rd_wr = 1; iss_rd = 9;
    tick();
    iss_long = 0; iss_rd_wr = 0; iss_rs1 = 9; iss_rs1_use = 1;
    repeat (10) @(posedge clk);
    #1; iss_valid = 0; iss_rs1_use = 0;
    tick();
`ifdef SB_PERF_CNT_EN
    check("perf_10", perf_stall_cnt, 10);
`else
    check("perf_tied0", perf_stall_cnt, 0);
`endif

    // Randomized run against the reference model
    do_reset();
    random_test(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
